// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the accumulator CPU's sequencer and decoder.
//   - 4-bit opcode constants (the decoder uses the same values)
//   - control-state enum for the fetch/execute sequencer
package cpu_pkg;

   localparam logic [3:0] OP_LDA       = 4'd0;
   localparam logic [3:0] OP_STA       = 4'd1;
   localparam logic [3:0] OP_ADD       = 4'd2;
   localparam logic [3:0] OP_SUB       = 4'd3;
   localparam logic [3:0] OP_JMP       = 4'd4;
   localparam logic [3:0] OP_JMI       = 4'd5;
   localparam logic [3:0] OP_JEQ       = 4'd6;
   localparam logic [3:0] OP_STP       = 4'd7;
   localparam logic [3:0] OP_LDI       = 4'd8;
   localparam logic [3:0] OP_MAX_LEGAL = 4'd8;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC1 = 2'd1,
      S_EXEC2 = 2'd2,
      S_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundle between the sequencer, instruction memory,
// decoder and run control.
//   master : sequencer side (drives state flags, IR, OPERAND, status)
//   slave  : memory/decoder/run-control side (drives MEM_Q, EXTRA, STEP*)
interface cpu_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) ();
   logic [DATA_W-1:0] MEM_Q;
   logic              EXTRA;
   logic              STEP_MODE;
   logic              STEP;
   logic              FETCH;
   logic              EXEC1;
   logic              EXEC2;
   logic              HALTED;
   logic [OP_W-1:0]   IR;
   logic [ADDR_W-1:0] OPERAND;
   logic              ILLEGAL;
   logic [CNT_W-1:0]  INSTR_COUNT;

   modport master (
      input  MEM_Q, EXTRA, STEP_MODE, STEP,
      output FETCH, EXEC1, EXEC2, HALTED, IR, OPERAND, ILLEGAL, INSTR_COUNT
   );

   modport slave (
      output MEM_Q, EXTRA, STEP_MODE, STEP,
      input  FETCH, EXEC1, EXEC2, HALTED, IR, OPERAND, ILLEGAL, INSTR_COUNT
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control-state sequencer and instruction register.
//   CLK   : rising-edge clock
//   RESET : synchronous, active-high; wins over everything, including S_HALT
//   bus   : cpu_sequencer_if.master
//           in  MEM_Q (valid in FETCH), EXTRA (sampled in EXEC1),
//               STEP_MODE/STEP (run control, sampled in FETCH only)
//           out FETCH/EXEC1/EXEC2/HALTED (one-hot state), IR, OPERAND,
//               ILLEGAL (sticky), INSTR_COUNT (wrapping)
// Every output is a flop or a decode of flops only; no input reaches an
// output combinationally.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   cpu_sequencer_if.master bus
);

   state_t            state, state_nxt;
   logic [OP_W-1:0]   ir;
   logic [ADDR_W-1:0] operand;
   logic              illegal;
   logic [CNT_W-1:0]  instr_count;
   logic              go;

   // Pad bits between opcode and operand carry no meaning here.
   logic              unused_pad;
   assign unused_pad = ^bus.MEM_Q;

   // Single-step: STEP held high behaves like free-running.
   assign go = !bus.STEP_MODE || bus.STEP;

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: if (go) state_nxt = S_EXEC1;
         S_EXEC1: begin
            // STP wins over EXTRA.
            if (ir == OP_W'(OP_STP)) state_nxt = S_HALT;
            else if (bus.EXTRA)      state_nxt = S_EXEC2;
            else                     state_nxt = S_FETCH;
         end
         S_EXEC2: state_nxt = S_FETCH;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

   // IR/OPERAND load only on the FETCH->EXEC1 edge so the decoder sees
   // them stable for the whole execute phase.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ir          <= '0;
         operand     <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         if (state == S_FETCH && go) begin
            ir          <= bus.MEM_Q[DATA_W-1 -: OP_W];
            operand     <= bus.MEM_Q[ADDR_W-1:0];
            instr_count <= instr_count + CNT_W'(1);
         end
         if (state == S_EXEC1 && ir > OP_W'(OP_MAX_LEGAL))
            illegal <= 1'b1;
      end
   end

   assign bus.FETCH       = (state == S_FETCH);
   assign bus.EXEC1       = (state == S_EXEC1);
   assign bus.EXEC2       = (state == S_EXEC2);
   assign bus.HALTED      = (state == S_HALT);
   assign bus.IR          = ir;
   assign bus.OPERAND     = operand;
   assign bus.ILLEGAL     = illegal;
   assign bus.INSTR_COUNT = instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed table, hand-written corner sequences, a
// randomized instruction stream against an instruction-level model, and a
// narrow-counter instance to cover counter wrap.
module tb_cpu_sequencer;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic RESET2 = 1'b1;
   always #5 CLK = ~CLK;

   cpu_sequencer_if #(.DATA_W(16), .OP_W(4), .ADDR_W(8), .CNT_W(16)) bus ();
   cpu_sequencer_if #(.DATA_W(16), .OP_W(4), .ADDR_W(8), .CNT_W(4))  bus2 ();

   cpu_sequencer #(.DATA_W(16), .OP_W(4), .ADDR_W(8), .CNT_W(16)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus)
   );
   cpu_sequencer #(.DATA_W(16), .OP_W(4), .ADDR_W(8), .CNT_W(4)) dut2 (
      .CLK(CLK), .RESET(RESET2), .bus(bus2)
   );

   int total = 0;
   int bad   = 0;

   // Expected phase names for the bench: F, E1, E2, H.
   localparam int PF = 0, PE1 = 1, PE2 = 2, PH = 3;

   typedef struct {
      logic [15:0] mem_q;
      logic        extra;
      logic        step_mode;
      logic        step;
      int          ph;
      logic [3:0]  ir;
      logic [7:0]  opnd;
      logic [15:0] cnt;
      logic        ill;
   } vec_t;

   function automatic logic [32:0] pack_exp(int ph, logic [3:0] ir,
         logic [7:0] opnd, logic [15:0] cnt, logic ill);
      logic [3:0] oh;
      oh = 4'b1000 >> ph;
      return {oh, ir, opnd, ill, cnt};
   endfunction

   function automatic logic [32:0] obs();
      return {bus.FETCH, bus.EXEC1, bus.EXEC2, bus.HALTED, bus.IR,
              bus.OPERAND, bus.ILLEGAL, bus.INSTR_COUNT};
   endfunction

   task automatic chk(string name, logic [32:0] got, logic [32:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {F,E1,E2,H,IR,OPND,ILL,CNT}=%b_%h_%h_%b_%h want %b_%h_%h_%b_%h",
                  name, got[32:29], got[28:25], got[24:17], got[16], got[15:0],
                  exp[32:29], exp[28:25], exp[24:17], exp[16], exp[15:0]);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   vec_t tbl[$];

   // Instruction-level reference state.
   logic [3:0]  m_ir;
   logic [7:0]  m_op;
   logic [15:0] m_cnt;
   logic        m_ill;

   initial begin
      bus.MEM_Q = 16'h0; bus.EXTRA = 1'b0; bus.STEP_MODE = 1'b0; bus.STEP = 1'b0;
      bus2.MEM_Q = 16'h0; bus2.EXTRA = 1'b0; bus2.STEP_MODE = 1'b0; bus2.STEP = 1'b0;

      // ---- reset state ----
      do_reset();
      chk("reset", obs(), pack_exp(PF, 4'h0, 8'h00, 16'd0, 1'b0));

      // ---- directed table: inputs applied before the edge, result after ----
      //          mem_q     ex    sm    st    ph   ir    opnd   cnt ill
      tbl.push_back('{16'h0012, 1'b0, 1'b0, 1'b0, PE1, 4'h0, 8'h12, 16'd1, 1'b0});
      tbl.push_back('{16'h0012, 1'b1, 1'b0, 1'b0, PE2, 4'h0, 8'h12, 16'd1, 1'b0});
      tbl.push_back('{16'h0012, 1'b0, 1'b0, 1'b0, PF,  4'h0, 8'h12, 16'd1, 1'b0});
      tbl.push_back('{16'h1034, 1'b0, 1'b0, 1'b0, PE1, 4'h1, 8'h34, 16'd2, 1'b0});
      tbl.push_back('{16'hFFFF, 1'b0, 1'b0, 1'b0, PF,  4'h1, 8'h34, 16'd2, 1'b0});
      tbl.push_back('{16'h2056, 1'b0, 1'b1, 1'b0, PF,  4'h1, 8'h34, 16'd2, 1'b0});
      tbl.push_back('{16'h2056, 1'b0, 1'b1, 1'b0, PF,  4'h1, 8'h34, 16'd2, 1'b0});
      tbl.push_back('{16'h2056, 1'b0, 1'b1, 1'b1, PE1, 4'h2, 8'h56, 16'd3, 1'b0});
      tbl.push_back('{16'h3077, 1'b0, 1'b1, 1'b0, PF,  4'h2, 8'h56, 16'd3, 1'b0});
      tbl.push_back('{16'h3077, 1'b0, 1'b1, 1'b0, PF,  4'h2, 8'h56, 16'd3, 1'b0});
      tbl.push_back('{16'hA000, 1'b0, 1'b0, 1'b0, PE1, 4'hA, 8'h00, 16'd4, 1'b0});
      tbl.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, PF,  4'hA, 8'h00, 16'd4, 1'b1});
      tbl.push_back('{16'h0001, 1'b0, 1'b0, 1'b0, PE1, 4'h0, 8'h01, 16'd5, 1'b1});
      tbl.push_back('{16'h0001, 1'b1, 1'b0, 1'b0, PE2, 4'h0, 8'h01, 16'd5, 1'b1});
      tbl.push_back('{16'h0001, 1'b0, 1'b0, 1'b0, PF,  4'h0, 8'h01, 16'd5, 1'b1});
      foreach (tbl[i]) begin
         bus.MEM_Q = tbl[i].mem_q; bus.EXTRA = tbl[i].extra;
         bus.STEP_MODE = tbl[i].step_mode; bus.STEP = tbl[i].step;
         tick();
         chk($sformatf("tbl[%0d]", i), obs(),
             pack_exp(tbl[i].ph, tbl[i].ir, tbl[i].opnd, tbl[i].cnt, tbl[i].ill));
      end

      // ---- STP with EXTRA forced high, then frozen for 20 cycles ----
      do_reset();
      bus.STEP_MODE = 1'b0; bus.STEP = 1'b0;
      bus.MEM_Q = 16'h7000; bus.EXTRA = 1'b1;
      tick();
      chk("stp_e1", obs(), pack_exp(PE1, 4'h7, 8'h00, 16'd1, 1'b0));
      tick();
      chk("stp_halt", obs(), pack_exp(PH, 4'h7, 8'h00, 16'd1, 1'b0));
      for (int i = 0; i < 20; i++) begin
         bus.MEM_Q = 16'(i * 16'h1111); bus.EXTRA = i[0];
         bus.STEP_MODE = i[1]; bus.STEP = i[2];
         tick();
         chk($sformatf("halt_hold%0d", i), obs(),
             pack_exp(PH, 4'h7, 8'h00, 16'd1, 1'b0));
      end
      do_reset();
      chk("halt_reset", obs(), pack_exp(PF, 4'h0, 8'h00, 16'd0, 1'b0));

      // ---- single-step: 5 held cycles, one STEP pulse, held again ----
      bus.STEP_MODE = 1'b1; bus.STEP = 1'b0; bus.EXTRA = 1'b0; bus.MEM_Q = 16'h3099;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("step_hold%0d", i), obs(), pack_exp(PF, 4'h0, 8'h00, 16'd0, 1'b0));
      end
      bus.STEP = 1'b1;
      tick();
      bus.STEP = 1'b0;
      chk("step_e1", obs(), pack_exp(PE1, 4'h3, 8'h99, 16'd1, 1'b0));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("step_after%0d", i), obs(), pack_exp(PF, 4'h3, 8'h99, 16'd1, 1'b0));
      end

      // ---- RESET during EXEC2 of an ADD ----
      bus.STEP_MODE = 1'b0; bus.MEM_Q = 16'h2042;
      tick();
      bus.EXTRA = 1'b1;
      tick();
      chk("add_e2", obs(), pack_exp(PE2, 4'h2, 8'h42, 16'd2, 1'b0));
      do_reset();
      chk("reset_in_e2", obs(), pack_exp(PF, 4'h0, 8'h00, 16'd0, 1'b0));

      // ---- counter wrap on the narrow instance (2 cycles/instruction) ----
      RESET2 = 1'b1;
      tick();
      RESET2 = 1'b0;
      for (int i = 0; i < 29; i++) tick();
      total++;
      if (bus2.INSTR_COUNT !== 4'd15) begin
         bad++;
         $display("FAIL wrap_pre: got %0d want 15", bus2.INSTR_COUNT);
      end
      tick(); tick();
      total++;
      if (bus2.INSTR_COUNT !== 4'd0 || bus2.EXEC1 !== 1'b1) begin
         bad++;
         $display("FAIL wrap: got cnt=%0d e1=%b want cnt=0 e1=1",
                  bus2.INSTR_COUNT, bus2.EXEC1);
      end

      // ---- randomized instruction stream vs instruction-level model ----
      do_reset();
      m_ir = 4'h0; m_op = 8'h00; m_cnt = 16'd0; m_ill = 1'b0;
      for (int n = 0; n < 300; n++) begin
         int stall;
         logic [15:0] w;
         logic ex;
         stall = int'($urandom_range(0, 3));
         for (int s = 0; s < stall; s++) begin
            bus.STEP_MODE = 1'b1; bus.STEP = 1'b0;
            bus.MEM_Q = 16'($urandom); bus.EXTRA = 1'($urandom);
            tick();
            chk($sformatf("rnd%0d_stall", n), obs(), pack_exp(PF, m_ir, m_op, m_cnt, m_ill));
         end
         w = 16'($urandom);
         if (w[15:12] == 4'h7 && $urandom_range(0, 3) != 0) w[15:12] = 4'h2;
         if ($urandom_range(0, 1) == 1) begin
            bus.STEP_MODE = 1'b0; bus.STEP = 1'($urandom);
         end else begin
            bus.STEP_MODE = 1'b1; bus.STEP = 1'b1;
         end
         bus.MEM_Q = w; bus.EXTRA = 1'($urandom);
         tick();
         m_ir = w[15:12]; m_op = w[7:0]; m_cnt = m_cnt + 16'd1;
         chk($sformatf("rnd%0d_e1", n), obs(), pack_exp(PE1, m_ir, m_op, m_cnt, m_ill));
         ex = 1'($urandom);
         bus.EXTRA = ex; bus.MEM_Q = 16'($urandom);
         bus.STEP_MODE = 1'($urandom); bus.STEP = 1'($urandom);
         tick();
         if (m_ir > 4'd8) m_ill = 1'b1;
         if (m_ir == 4'd7) begin
            chk($sformatf("rnd%0d_halt", n), obs(), pack_exp(PH, m_ir, m_op, m_cnt, m_ill));
            tick();
            chk($sformatf("rnd%0d_halt2", n), obs(), pack_exp(PH, m_ir, m_op, m_cnt, m_ill));
            do_reset();
            m_ir = 4'h0; m_op = 8'h00; m_cnt = 16'd0; m_ill = 1'b0;
            chk($sformatf("rnd%0d_rst", n), obs(), pack_exp(PF, m_ir, m_op, m_cnt, m_ill));
         end else if (ex) begin
            chk($sformatf("rnd%0d_e2", n), obs(), pack_exp(PE2, m_ir, m_op, m_cnt, m_ill));
            bus.STEP_MODE = 1'($urandom); bus.STEP = 1'($urandom);
            bus.MEM_Q = 16'($urandom);
            tick();
            chk($sformatf("rnd%0d_f", n), obs(), pack_exp(PF, m_ir, m_op, m_cnt, m_ill));
         end else begin
            chk($sformatf("rnd%0d_f", n), obs(), pack_exp(PF, m_ir, m_op, m_cnt, m_ill));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
